// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared widths and control-bundle layout for the EX/MEM register
package ex_mem_reg_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  // Control bundle bit positions
  localparam int CTRL_W          = 6;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_LINK       = 4;
  localparam int CTRL_HALT       = 5;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_mem_reg_if.sv
// rtl/ex_mem_reg_if.sv - EX-side inputs, MEM-side outputs and hazard signals of the EX/MEM register
interface ex_mem_reg_if;
  import ex_mem_reg_pkg::*;

  logic          ex_valid;
  logic [DW-1:0] ex_result;
  logic [DW-1:0] ex_st_data;
  logic [DW-1:0] ex_pc_inc;
  logic [RW-1:0] ex_wr_reg;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          ex_link;
  logic          ex_halt;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;

  logic          mem_valid;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_st_data;
  logic [DW-1:0] mem_pc_inc;
  logic [RW-1:0] mem_wr_reg;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic          mem_mem_to_reg;
  logic          mem_link;
  logic          mem_halt;
  logic          fwd_rs_hit;
  logic          fwd_rt_hit;
  logic          load_use;
  logic          halt_seen;
  logic          err;

  modport master (
    output ex_valid, ex_result, ex_st_data, ex_pc_inc, ex_wr_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_link, ex_halt, id_rs, id_rt,
    input  mem_valid, mem_result, mem_st_data, mem_pc_inc, mem_wr_reg, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_link, mem_halt,
           fwd_rs_hit, fwd_rt_hit, load_use, halt_seen, err
  );

  modport slave (
    input  ex_valid, ex_result, ex_st_data, ex_pc_inc, ex_wr_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_link, ex_halt, id_rs, id_rt,
    output mem_valid, mem_result, mem_st_data, mem_pc_inc, mem_wr_reg, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_link, mem_halt,
           fwd_rs_hit, fwd_rt_hit, load_use, halt_seen, err
  );

endinterface

// File: rtl/ex_mem_reg_dff_en_clr.sv
// rtl/ex_mem_reg_dff_en_clr.sv - width-parameterised flop with synchronous clear (dominant) and enable
module dff_en_clr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with stall/flush, sticky halt/err and forward matching
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  ex_mem_reg_if.slave  bus
);

  logic          load_en;
  logic          pipe_clr;
  logic          pipe_en;
  ctrl_t         ctrl_d;
  ctrl_t         ctrl_q;
  logic          valid_q;
  logic [DW-1:0] result_q;
  logic [DW-1:0] st_data_q;
  logic [DW-1:0] pc_inc_q;
  logic [RW-1:0] wr_reg_q;
  logic          halt_seen_d;
  logic          halt_seen_q;
  logic          err_d;
  logic          err_q;

  // Clear beats enable inside the flop, so rst wins over stall and a flush only lands when not stalled.
  assign pipe_clr = rst | (flush & ~stall);
  assign pipe_en  = ~stall;
  assign load_en  = ~stall & ~flush;

  always_comb begin
    ctrl_d = CTRL_BUBBLE;
    if (bus.ex_valid) begin
      ctrl_d[CTRL_REG_WRITE]  = bus.ex_reg_write;
      ctrl_d[CTRL_MEM_READ]   = bus.ex_mem_read;
      ctrl_d[CTRL_MEM_WRITE]  = bus.ex_mem_write;
      ctrl_d[CTRL_MEM_TO_REG] = bus.ex_mem_to_reg;
      ctrl_d[CTRL_LINK]       = bus.ex_link;
      ctrl_d[CTRL_HALT]       = bus.ex_halt;
    end
  end

  assign halt_seen_d = halt_seen_q | (bus.ex_valid & bus.ex_halt);
  assign err_d       = err_q | (bus.ex_valid & bus.ex_mem_read & bus.ex_mem_write);

  dff_en_clr #(.W(1))      u_valid   (.clk(clk), .clr(pipe_clr), .en(pipe_en), .d(bus.ex_valid),   .q(valid_q));
  dff_en_clr #(.W(DW))     u_result  (.clk(clk), .clr(pipe_clr), .en(pipe_en), .d(bus.ex_result),  .q(result_q));
  dff_en_clr #(.W(DW))     u_st_data (.clk(clk), .clr(pipe_clr), .en(pipe_en), .d(bus.ex_st_data), .q(st_data_q));
  dff_en_clr #(.W(DW))     u_pc_inc  (.clk(clk), .clr(pipe_clr), .en(pipe_en), .d(bus.ex_pc_inc),  .q(pc_inc_q));
  dff_en_clr #(.W(RW))     u_wr_reg  (.clk(clk), .clr(pipe_clr), .en(pipe_en), .d(bus.ex_wr_reg),  .q(wr_reg_q));
  dff_en_clr #(.W(CTRL_W)) u_ctrl    (.clk(clk), .clr(pipe_clr), .en(pipe_en), .d(ctrl_d),         .q(ctrl_q));

  // Sticky flags only accumulate on a real load and are cleared solely by reset.
  dff_en_clr #(.W(1)) u_halt_seen (.clk(clk), .clr(rst), .en(load_en), .d(halt_seen_d), .q(halt_seen_q));
  dff_en_clr #(.W(1)) u_err       (.clk(clk), .clr(rst), .en(load_en), .d(err_d),       .q(err_q));

  assign bus.mem_valid      = valid_q;
  assign bus.mem_result     = result_q;
  assign bus.mem_st_data    = st_data_q;
  assign bus.mem_pc_inc     = pc_inc_q;
  assign bus.mem_wr_reg     = wr_reg_q;
  assign bus.mem_reg_write  = ctrl_q[CTRL_REG_WRITE];
  assign bus.mem_mem_read   = ctrl_q[CTRL_MEM_READ];
  assign bus.mem_mem_write  = ctrl_q[CTRL_MEM_WRITE];
  assign bus.mem_mem_to_reg = ctrl_q[CTRL_MEM_TO_REG];
  assign bus.mem_link       = ctrl_q[CTRL_LINK];
  assign bus.mem_halt       = ctrl_q[CTRL_HALT];
  assign bus.halt_seen      = halt_seen_q;
  assign bus.err            = err_q;

  // A load result is not ready in MEM, so it is reported as load_use rather than forwarded.
  assign bus.fwd_rs_hit = valid_q & ctrl_q[CTRL_REG_WRITE] & ~ctrl_q[CTRL_MEM_READ] & (wr_reg_q == bus.id_rs);
  assign bus.fwd_rt_hit = valid_q & ctrl_q[CTRL_REG_WRITE] & ~ctrl_q[CTRL_MEM_READ] & (wr_reg_q == bus.id_rt);
  assign bus.load_use   = valid_q & ctrl_q[CTRL_MEM_READ] &
                          ((wr_reg_q == bus.id_rs) | (wr_reg_q == bus.id_rt));

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
EX/MEM pipeline register for the 5-stage pipeline. It sits directly downstream of the execute stage, i.e. the ALU and its shifter (SLL/SRL/ROL). It captures the EX result, store data, destination register and memory/writeback controls, and presents them to the MEM stage. It also provides stall/flush handling, a sticky halt flag, an illegal-control error flag, and EX→EX forwarding match signals for the hazard unit.

Parameters:
DW, 16, datapath width (result, store data, PC).
RW, 3, register-specifier width (8 GPRs).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold all EX/MEM contents (MEM stage busy)
flush  in  1  load a bubble instead of EX contents
ex_valid  in  1  EX holds a real instruction
ex_result  in  DW  ALU/shifter result
ex_st_data  in  DW  Rt value for stores
ex_pc_inc  in  DW  PC+2, used for link writeback
ex_wr_reg  in  RW  destination register
ex_reg_write  in  1  writes register file
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_mem_to_reg  in  1  writeback selects memory data
ex_link  in  1  writeback selects PC+2
ex_halt  in  1  HALT instruction
id_rs  in  RW  source Rs of the instruction in ID/EX
id_rt  in  RW  source Rt of the instruction in ID/EX
mem_valid, mem_result, mem_st_data, mem_pc_inc, mem_wr_reg, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_link, mem_halt  out  widths as EX counterparts  registered copies
fwd_rs_hit  out  1  mem_valid & mem_reg_write & ~mem_mem_read & (mem_wr_reg==id_rs)
fwd_rt_hit  out  1  same, compared against id_rt
load_use  out  1  mem_valid & mem_mem_read & (mem_wr_reg==id_rs | mem_wr_reg==id_rt)
halt_seen  out  1  sticky; set once a valid HALT is captured
err  out  1  sticky; set if a valid instruction is captured with ex_mem_read & ex_mem_write

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. While rst=1 at a clk edge, all registered outputs are cleared to 0 next cycle: valid, data, controls, halt_seen, err.
- Latency: 1 cycle EX→MEM. Forward/load_use outputs are combinational from the registered state plus id_rs/id_rt.
- Priority per edge: rst > stall > flush > load.
- stall=1: every register holds, including the sticky flags. Flush is ignored while stalled; upstream re-asserts it.
- flush=1 (no stall): mem_valid←0 and all control bits (reg_write, mem_read, mem_write, mem_to_reg, link, halt)←0. Data fields (result, st_data, pc_inc, wr_reg) are don't-care; the implementation clears them to 0.
- Load (no stall, no flush): all fields←EX inputs.
  - When ex_valid=0, controls are forced to 0 so a bubble can never write.
  - A bubble compares as no match on all forward/load_use outputs.
- halt_seen: set on a load with ex_valid & ex_halt; cleared only by rst.
- err: set on a load with ex_valid & ex_mem_read & ex_mem_write. The offending controls are still captured unchanged (MEM decides). Cleared only by rst.
- Register 0 is an ordinary register (no hardwired zero). Matching on wr_reg==0 is legal.
- A store (mem_write) with reg_write=0 never produces a forward hit.
- Reset mid-stall: rst wins; the bubble appears next cycle.

Decomposition:
- Shared package/include:
  - DW and RW constants.
  - Control-bundle bit positions: REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG, LINK, HALT, a 6-bit bundle.
  - Reset/bubble value of the bundle (all zero).
- One natural sub-module: dff_en_clr (a width-parameterised D flip-flop with synchronous clear and enable), instantiated per field.
- Forward compare logic stays in this block.

Test Plan:
- rst=1 for 2 cycles with ex_valid=1, ex_result=16'hBEEF → mem_valid=0, mem_result=0, halt_seen=0, err=0; one cycle after release, mem_result=16'hBEEF.
- Load ex_result=16'h00F0 (SLL 4 of 16'h000F), ex_wr_reg=3, reg_write=1; id_rs=3 → next cycle mem_result=16'h00F0, fwd_rs_hit=1, fwd_rt_hit=0.
- Capture a load (mem_read=1, wr_reg=5); id_rt=5 → load_use=1, fwd_rt_hit=0. Then stall=1 for 3 cycles with new EX data → outputs unchanged, load_use stays 1.
- flush=1 with ex_valid=1, reg_write=1, mem_write=1 → mem_valid=0, mem_reg_write=0, mem_mem_write=0. With stall=1 and flush=1 together, contents are held.
- ex_valid=1, ex_halt=1, then a bubble, then normal instructions → halt_seen=1 from the cycle after capture and stays 1 until rst.
- ex_valid=1 with mem_read=mem_write=1 → err=1 sticky. The same pattern with ex_valid=0 leaves err=0.
